stack_sequencer: RTL and testbench

- Multi-cycle engine that performs CALL/RET/INT/RTI stack traffic for the pipeline.
- Data memory is 16 bits wide, so a 32-bit PC is pushed or popped as two words. INT/RTI add a third word for the CCR.
- Sits beside the memory stage. It is the writer of the register file's SP, PC and CCR write ports (sp_write/write_sp_data, write_pc_data, write_ccr), and it stalls the pipeline while busy.

---
 rtl/stack_pkg.sv | 34 +++
 rtl/stack_sequencer.sv | 272 +++++++++++++++++++++++++++
 tb/tb_stack_sequencer.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the stack sequencer: op encodings, FSM state
// encoding and the default top-of-stack value.
package stack_pkg;

    localparam logic [1:0] OP_CALL = 2'b00;
    localparam logic [1:0] OP_RET  = 2'b01;
    localparam logic [1:0] OP_INT  = 2'b10;
    localparam logic [1:0] OP_RTI  = 2'b11;

    // Matches the register file's SP reset value.
    localparam int SP_RESET_DEF = 2047;

    typedef enum logic [2:0] {
        IDLE,
        PUSH_HI,
        PUSH_LO,
        PUSH_CCR,
        POP_CCR,
        POP_LO,
        POP_HI,
        DONE
    } state_e;

    // CALL and INT push; RET and RTI pop.
    function automatic logic op_is_push(input logic [1:0] op);
        return ~op[0];
    endfunction

    // INT and RTI move three words (PC pair plus CCR); CALL and RET move two.
    function automatic logic op_has_ccr(input logic [1:0] op);
        return op[1];
    endfunction

endpackage

// File: rtl/stack_sequencer.sv
// stack_sequencer: multi-cycle engine for CALL/RET/INT/RTI stack traffic.
// A 32-bit PC moves as two 16-bit memory words (high word at the higher
// address); INT/RTI add a CCR word below the PC. SP points to the next free
// word and the stack grows downward.
//
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   start, op           request (sampled only in IDLE) and its opcode
//   ret_pc, target_pc   PC to push, PC to jump to (CALL/INT)
//   ccr_in, sp_in       CCR to push (INT), current SP
//   mem_*               single-request memory port, completes on mem_ready
//   sp_/pc_/ccr_write   1-cycle register file write strobes with their data
//   busy, done          pipeline stall, completion pulse
//   stack_fault         rejected-request pulse (guard builds only)
//
// Build option: define STACK_GUARD_EN to reject pushes that would take SP
// below SP_LIMIT and pops that would take SP above SP_RESET. Without it SP
// wraps modulo 2^ADDR_W and stack_fault stays 0.
module stack_sequencer
    import stack_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 32,
    parameter int PC_W     = 32,
    parameter int SP_RESET = SP_RESET_DEF,
    parameter int SP_LIMIT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [PC_W-1:0]   ret_pc,
    input  logic [PC_W-1:0]   target_pc,
    input  logic [DATA_W-1:0] ccr_in,
    input  logic [ADDR_W-1:0] sp_in,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              sp_write,
    output logic [ADDR_W-1:0] sp_wdata,
    output logic              pc_write,
    output logic [PC_W-1:0]   pc_wdata,
    output logic              ccr_write,
    output logic [DATA_W-1:0] ccr_wdata,
    output logic              busy,
    output logic              done,
    output logic              stack_fault
);

    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    // Working state
    state_e              state_q, state_d;
    logic [1:0]          op_q, op_d;
    logic [PC_W-1:0]     ret_pc_q, ret_pc_d;
    logic [PC_W-1:0]     target_q, target_d;
    logic [DATA_W-1:0]   ccr_q, ccr_d;
    logic [ADDR_W-1:0]   sp_q, sp_d;
    logic [PC_W-1:0]     pc_rd_q, pc_rd_d;
    logic [DATA_W-1:0]   ccr_rd_q, ccr_rd_d;

    // Registered outputs
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                mem_we_q, mem_we_d;
    logic                mem_re_q, mem_re_d;
    logic                sp_write_q, sp_write_d;
    logic [ADDR_W-1:0]   sp_wdata_q, sp_wdata_d;
    logic                pc_write_q, pc_write_d;
    logic [PC_W-1:0]     pc_wdata_q, pc_wdata_d;
    logic                ccr_write_q, ccr_write_d;
    logic [DATA_W-1:0]   ccr_wdata_q, ccr_wdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                fault_q, fault_d;

    logic                reject;

`ifdef STACK_GUARD_EN
    // Bounds are compared one bit wider than SP so that wrap-around in
    // either direction shows up as out-of-range instead of aliasing.
    localparam int              EW      = ADDR_W + 1;
    localparam logic [ADDR_W:0] LIM_EXT = EW'(SP_LIMIT);
    localparam logic [ADDR_W:0] TOP_EXT = EW'(SP_RESET);

    logic [ADDR_W:0] sp_ext, n_ext;
    assign sp_ext = {1'b0, sp_in};
    assign n_ext  = op_has_ccr(op) ? EW'(3) : EW'(2);
    assign reject = op_is_push(op) ? (sp_ext < LIM_EXT + n_ext)
                                   : (sp_ext + n_ext > TOP_EXT);
`else
    logic unused_guard;
    assign unused_guard = ^{32'(SP_RESET), 32'(SP_LIMIT)};
    assign reject       = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        ret_pc_d = ret_pc_q;
        target_d = target_q;
        ccr_d    = ccr_q;
        sp_d     = sp_q;
        pc_rd_d  = pc_rd_q;
        ccr_rd_d = ccr_rd_q;
        fault_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (reject) begin
                        fault_d = 1'b1;
                    end else begin
                        op_d     = op;
                        ret_pc_d = ret_pc;
                        target_d = target_pc;
                        ccr_d    = ccr_in;
                        sp_d     = sp_in;
                        if (op_is_push(op))  state_d = PUSH_HI;
                        else if (op == OP_RTI) state_d = POP_CCR;
                        else                 state_d = POP_LO;
                    end
                end
            end
            PUSH_HI: if (mem_ready) begin
                sp_d    = sp_q - ONE;
                state_d = PUSH_LO;
            end
            PUSH_LO: if (mem_ready) begin
                sp_d    = sp_q - ONE;
                state_d = (op_q == OP_INT) ? PUSH_CCR : DONE;
            end
            PUSH_CCR: if (mem_ready) begin
                sp_d    = sp_q - ONE;
                state_d = DONE;
            end
            POP_CCR: if (mem_ready) begin
                sp_d     = sp_q + ONE;
                ccr_rd_d = mem_rdata;
                state_d  = POP_LO;
            end
            POP_LO: if (mem_ready) begin
                sp_d                 = sp_q + ONE;
                pc_rd_d[DATA_W-1:0]  = mem_rdata;
                state_d              = POP_HI;
            end
            POP_HI: if (mem_ready) begin
                sp_d                   = sp_q + ONE;
                pc_rd_d[PC_W-1 -: DATA_W] = mem_rdata;
                state_d                = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are a function of the state being entered, so they appear
        // in the same cycle as that state and stay put while it waits.
        mem_addr_d  = '0;
        mem_wdata_d = '0;
        mem_we_d    = 1'b0;
        mem_re_d    = 1'b0;
        sp_write_d  = 1'b0;
        sp_wdata_d  = '0;
        pc_write_d  = 1'b0;
        pc_wdata_d  = '0;
        ccr_write_d = 1'b0;
        ccr_wdata_d = '0;
        done_d      = 1'b0;
        busy_d      = (state_d != IDLE);

        case (state_d)
            PUSH_HI: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_d;
                mem_wdata_d = ret_pc_d[PC_W-1 -: DATA_W];
            end
            PUSH_LO: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_d;
                mem_wdata_d = ret_pc_d[DATA_W-1:0];
            end
            PUSH_CCR: begin
                mem_we_d    = 1'b1;
                mem_addr_d  = sp_d;
                mem_wdata_d = ccr_d;
            end
            // Pops pre-increment: the word lives one above the working SP.
            POP_CCR, POP_LO, POP_HI: begin
                mem_re_d   = 1'b1;
                mem_addr_d = sp_d + ONE;
            end
            DONE: begin
                done_d     = 1'b1;
                sp_write_d = 1'b1;
                sp_wdata_d = sp_d;
                pc_write_d = 1'b1;
                pc_wdata_d = op_is_push(op_d) ? target_d : pc_rd_d;
                if (op_d == OP_RTI) begin
                    ccr_write_d = 1'b1;
                    ccr_wdata_d = ccr_rd_d;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            op_q        <= '0;
            ret_pc_q    <= '0;
            target_q    <= '0;
            ccr_q       <= '0;
            sp_q        <= '0;
            pc_rd_q     <= '0;
            ccr_rd_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            sp_write_q  <= 1'b0;
            sp_wdata_q  <= '0;
            pc_write_q  <= 1'b0;
            pc_wdata_q  <= '0;
            ccr_write_q <= 1'b0;
            ccr_wdata_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            ret_pc_q    <= ret_pc_d;
            target_q    <= target_d;
            ccr_q       <= ccr_d;
            sp_q        <= sp_d;
            pc_rd_q     <= pc_rd_d;
            ccr_rd_q    <= ccr_rd_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            mem_re_q    <= mem_re_d;
            sp_write_q  <= sp_write_d;
            sp_wdata_q  <= sp_wdata_d;
            pc_write_q  <= pc_write_d;
            pc_wdata_q  <= pc_wdata_d;
            ccr_write_q <= ccr_write_d;
            ccr_wdata_q <= ccr_wdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign mem_we      = mem_we_q;
    assign mem_re      = mem_re_q;
    assign sp_write    = sp_write_q;
    assign sp_wdata    = sp_wdata_q;
    assign pc_write    = pc_write_q;
    assign pc_wdata    = pc_wdata_q;
    assign ccr_write   = ccr_write_q;
    assign ccr_wdata   = ccr_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign stack_fault = fault_q;

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer. Each request pushes its expected
// memory writes and completion record; monitors pop and compare them as the
// DUT writes memory and pulses done. Guard behaviour follows STACK_GUARD_EN.
module tb_stack_sequencer;
    import stack_pkg::*;

    localparam int SP_LIM = 2045;
    localparam int SP_TOP = 2047;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] ret_pc = '0, target_pc = '0, sp_in = '0;
    logic [15:0] ccr_in = '0;
    logic [31:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic        mem_ready = 1'b1;
    logic        sp_write, pc_write, ccr_write, busy, done, stack_fault;
    logic [31:0] sp_wdata, pc_wdata;
    logic [15:0] ccr_wdata;

    stack_sequencer #(.SP_RESET(SP_TOP), .SP_LIMIT(SP_LIM)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .ret_pc(ret_pc),
        .target_pc(target_pc), .ccr_in(ccr_in), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .sp_write(sp_write), .sp_wdata(sp_wdata), .pc_write(pc_write),
        .pc_wdata(pc_wdata), .ccr_write(ccr_write), .ccr_wdata(ccr_wdata),
        .busy(busy), .done(done), .stack_fault(stack_fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] sp;
        logic [31:0] pc;
        logic        ccrw;
        logic [15:0] ccr;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [15:0] data;
    } wr_t;

    exp_t exp_q[$];
    wr_t  wr_q[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;

    logic [15:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = '0;

    assign mem_rdata = mem[mem_addr[11:0]];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rst && mem_we && mem_ready) mem[mem_addr[11:0]] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Write monitor and completion monitor.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            chk("we_re_excl", mem_re, 0);
            if (mem_ready) begin
                if (wr_q.size() == 0) chk("unexp_write", 1, 0);
                else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_addr", mem_addr, w.addr);
                    chk("wr_data", mem_wdata, w.data);
                end
            end
        end
        if (rst && done) begin
            if (exp_q.size() == 0) chk("unexp_done", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("done_cyc", cyc, e.cyc);
                chk("sp_write", sp_write, 1);
                chk("sp_wdata", sp_wdata, e.sp);
                chk("pc_write", pc_write, 1);
                chk("pc_wdata", pc_wdata, e.pc);
                chk("ccr_write", ccr_write, e.ccrw);
                if (e.ccrw) chk("ccr_wdata", ccr_wdata, e.ccr);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_addr"}, mem_addr, 0);
        chk({tag, "_wdata"}, mem_wdata, 0);
        chk({tag, "_flags"}, {mem_we, mem_re, sp_write, pc_write, ccr_write, done, busy, stack_fault}, 0);
        chk({tag, "_spw"}, sp_wdata, 0);
        chk({tag, "_pcw"}, pc_wdata, 0);
        chk({tag, "_ccrw"}, ccr_wdata, 0);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((exp_q.size() != 0 || busy) && k < 60) begin
            @(negedge clk);
            k++;
        end
        chk("timeout", k >= 60, 0);
        chk("writes_left", wr_q.size(), 0);
    endtask

    task automatic run_op(input logic [1:0] o, input logic [31:0] sp, input logic [31:0] ret,
                          input logic [31:0] tgt, input logic [15:0] cc, input int stall);
        int n, t, k;
        bit push, rej;
        exp_t e;
        logic [31:0] a;
        push = (o == OP_CALL) || (o == OP_INT);
        n = (o == OP_INT || o == OP_RTI) ? 3 : 2;
        rej = 1'b0;
`ifdef STACK_GUARD_EN
        if (push) rej = ({1'b0, sp} < 33'(SP_LIM) + 33'(n));
        else      rej = ({1'b0, sp} + 33'(n) > 33'(SP_TOP));
`endif
        e.ccrw = 1'b0;
        e.ccr  = '0;
        if (push) begin
            e.pc = tgt;
            e.sp = sp - n;
            if (!rej) begin
                wr_q.push_back('{sp, ret[31:16]});
                wr_q.push_back('{sp - 1, ret[15:0]});
                if (n == 3) wr_q.push_back('{sp - 2, cc});
            end
        end else begin
            k = 1;
            if (n == 3) begin
                a = sp + 1;
                e.ccr  = mem[a[11:0]];
                e.ccrw = 1'b1;
                k = 2;
            end
            a = sp + k;
            e.pc[15:0] = mem[a[11:0]];
            a = sp + k + 1;
            e.pc[31:16] = mem[a[11:0]];
            e.sp = sp + n;
        end
        @(negedge clk);
        op = o; sp_in = sp; ret_pc = ret; target_pc = tgt; ccr_in = cc; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        t = cyc;
        if (!rej) begin
            e.cyc = t + n + stall;
            exp_q.push_back(e);
        end
        @(negedge clk);
        chk("fault_pulse", stack_fault, rej);
        chk("busy_after_start", busy, !rej);
        if (stall > 0 && !rej) begin
            @(posedge clk);
            #1 mem_ready = 1'b0;
            repeat (stall) begin
                @(negedge clk);
                chk("stall_addr", mem_addr, sp - 1);
                chk("stall_wdata", mem_wdata, ret[15:0]);
                op = OP_RET; start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
            mem_ready = 1'b1;
        end
        @(negedge clk);
        chk("fault_clear", stack_fault, 0);
        wait_idle();
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b1;
        repeat (2) @(negedge clk);

        run_op(OP_CALL, 32'd2047, 32'h0001_0020, 32'h0000_0100, 16'h0, 0);
        run_op(OP_RET,  32'd2045, 32'h0, 32'h0, 16'h0, 0);
        run_op(OP_INT,  32'd2047, 32'h0002_0040, 32'h0000_0200, 16'h0005, 0);
        run_op(OP_RTI,  32'd2044, 32'h0, 32'h0, 16'h0, 0);
        run_op(OP_CALL, 32'd2047, 32'h1234_5678, 32'h0000_0300, 16'h0, 3);
        run_op(OP_RET,  32'd2045, 32'h0, 32'h0, 16'h0, 0);

        // Reset while in PUSH_LO: only the PUSH_HI write may land.
        @(negedge clk);
        op = OP_CALL; sp_in = 32'd2047; ret_pc = 32'hAAAA_5555; target_pc = 32'h400; start = 1'b1;
        wr_q.push_back('{32'd2047, 16'hAAAA});
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        #1 chk_all_zero("midreset");
        chk("midreset_wr", wr_q.size(), 0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("midreset_nodone", exp_q.size(), 0);
        run_op(OP_CALL, 32'd2047, 32'h0003_0060, 32'h0000_0500, 16'h0, 0);

        // Guard boundary and wrap cases (rejected in guard builds).
        run_op(OP_CALL, 32'd2046, 32'h0004_0080, 32'h0000_0600, 16'h0, 0);
        run_op(OP_CALL, 32'd1,    32'h0005_00A0, 32'h0000_0700, 16'h0, 0);
        run_op(OP_RET,  32'hFFFF_FFFF, 32'h0, 32'h0, 16'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
